// File: rtl/pipeline_control_unit_pkg.sv
// Shared definitions for the pipelined control unit: opcodes, ALUOp and
// forwarding-select encodings, and the control bundle carried down the pipe.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ALU_I  = 2'b00,
    ALU_S  = 2'b01,
    ALU_R  = 2'b10,
    ALU_SB = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_to_reg;
    logic    mem_read;
    logic    mem_write;
    logic    alu_src;
    logic    branch;
    alu_op_e alu_op;
    logic    illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = ctrl_t'('0);

endpackage

// File: rtl/pipeline_control_unit_if.sv
// ID-side inputs and stage-control outputs of the pipeline control unit.
// The datapath side is the master; the control unit is the slave.
interface pipeline_control_unit_if #(parameter int REG_AW = 5);

  logic              id_valid_i;
  logic [6:0]        id_op_i;
  logic [REG_AW-1:0] id_rs1_i;
  logic [REG_AW-1:0] id_rs2_i;
  logic [REG_AW-1:0] id_rd_i;
  logic              ex_zero_i;

  logic              stall_o;
  logic              flush_o;
  logic [1:0]        ex_alu_op_o;
  logic              ex_alu_src_o;
  logic              ex_branch_o;
  logic              ex_illegal_o;
  logic [1:0]        fwd_a_o;
  logic [1:0]        fwd_b_o;
  logic              mem_read_o;
  logic              mem_write_o;
  logic              wb_reg_write_o;
  logic              wb_mem_to_reg_o;
  logic [REG_AW-1:0] wb_rd_o;

  modport master (
    output id_valid_i, id_op_i, id_rs1_i, id_rs2_i, id_rd_i, ex_zero_i,
    input  stall_o, flush_o, ex_alu_op_o, ex_alu_src_o, ex_branch_o,
           ex_illegal_o, fwd_a_o, fwd_b_o, mem_read_o, mem_write_o,
           wb_reg_write_o, wb_mem_to_reg_o, wb_rd_o
  );

  modport slave (
    input  id_valid_i, id_op_i, id_rs1_i, id_rs2_i, id_rd_i, ex_zero_i,
    output stall_o, flush_o, ex_alu_op_o, ex_alu_src_o, ex_branch_o,
           ex_illegal_o, fwd_a_o, fwd_b_o, mem_read_o, mem_write_o,
           wb_reg_write_o, wb_mem_to_reg_o, wb_rd_o
  );

endinterface

// File: rtl/pipeline_control_unit_decoder.sv
// Combinational RV32I opcode decoder for the ID stage: control bundle plus
// which source registers the instruction actually reads.
module control_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] id_op_i,
  input  logic       id_valid_i,
  output ctrl_t      ctrl_o,
  output logic       uses_rs1_o,
  output logic       uses_rs2_o
);

  always_comb begin
    ctrl_o     = CTRL_BUBBLE;
    uses_rs1_o = 1'b0;
    uses_rs2_o = 1'b0;
    if (id_valid_i) begin
      unique case (id_op_i)
        OP_R: begin
          ctrl_o.reg_write = 1'b1;
          ctrl_o.alu_op    = ALU_R;
          uses_rs1_o       = 1'b1;
          uses_rs2_o       = 1'b1;
        end
        OP_I_ALU: begin
          ctrl_o.reg_write = 1'b1;
          ctrl_o.alu_src   = 1'b1;
          ctrl_o.alu_op    = ALU_I;
          uses_rs1_o       = 1'b1;
        end
        OP_LOAD: begin
          ctrl_o.reg_write  = 1'b1;
          ctrl_o.mem_to_reg = 1'b1;
          ctrl_o.mem_read   = 1'b1;
          ctrl_o.alu_src    = 1'b1;
          ctrl_o.alu_op     = ALU_I;
          uses_rs1_o        = 1'b1;
        end
        OP_STORE: begin
          ctrl_o.mem_write = 1'b1;
          ctrl_o.alu_src   = 1'b1;
          ctrl_o.alu_op    = ALU_S;
          uses_rs1_o       = 1'b1;
          uses_rs2_o       = 1'b1;
        end
        OP_BRANCH: begin
          ctrl_o.branch = 1'b1;
          ctrl_o.alu_op = ALU_SB;
          uses_rs1_o    = 1'b1;
          uses_rs2_o    = 1'b1;
        end
        default: ctrl_o.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/pipeline_control_unit.sv
// Pipelined control unit for the 5-stage RV32I core: decodes ID, owns the
// ID/EX, EX/MEM and MEM/WB control registers, and resolves hazards.
module pipeline_control_unit
  import ctrl_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter bit ENABLE_FWD = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  pipeline_control_unit_if.slave bus
);

  ctrl_t id_ctrl;
  logic  id_uses_rs1;
  logic  id_uses_rs2;

  ctrl_t             ex_ctrl_p0;
  logic              vld_p0;
  logic [REG_AW-1:0] ex_rs1_p0;
  logic [REG_AW-1:0] ex_rs2_p0;
  logic [REG_AW-1:0] ex_rd_p0;

  logic              vld_p1;
  logic              mem_reg_write_p1;
  logic              mem_to_reg_p1;
  logic              mem_read_p1;
  logic              mem_write_p1;
  logic [REG_AW-1:0] mem_rd_p1;

  logic              vld_p2;
  logic              wb_reg_write_p2;
  logic              wb_mem_to_reg_p2;
  logic [REG_AW-1:0] wb_rd_p2;

  control_decoder u_decoder (
    .id_op_i    (bus.id_op_i),
    .id_valid_i (bus.id_valid_i),
    .ctrl_o     (id_ctrl),
    .uses_rs1_o (id_uses_rs1),
    .uses_rs2_o (id_uses_rs2)
  );

  function automatic logic src_hit(input logic [REG_AW-1:0] rd,
                                   input logic use1, input logic [REG_AW-1:0] rs1,
                                   input logic use2, input logic [REG_AW-1:0] rs2);
    return (rd != '0) && ((use1 && rs1 == rd) || (use2 && rs2 == rd));
  endfunction

  function automatic fwd_sel_e fwd_select(input logic [REG_AW-1:0] rs,
                                          input logic mem_src, input logic [REG_AW-1:0] mem_rd,
                                          input logic wb_src,  input logic [REG_AW-1:0] wb_rd);
    if (mem_src && mem_rd == rs) return FWD_MEM;
    if (wb_src && wb_rd == rs)   return FWD_WB;
    return FWD_RF;
  endfunction

  logic ex_hit;
  logic mem_hit;
  logic load_use;
  logic raw_stall;
  logic flush;
  logic insert_bubble;
  logic mem_fwd_src;
  logic wb_fwd_src;

  assign ex_hit  = src_hit(ex_rd_p0, id_uses_rs1, bus.id_rs1_i, id_uses_rs2, bus.id_rs2_i);
  assign mem_hit = src_hit(mem_rd_p1, id_uses_rs1, bus.id_rs1_i, id_uses_rs2, bus.id_rs2_i);

  assign load_use  = vld_p0 && ex_ctrl_p0.mem_read && ex_hit;
  // Without forwarding every producer still in EX or MEM must drain first;
  // WB is safe because the register file writes through.
  assign raw_stall = !ENABLE_FWD &&
                     ((vld_p0 && ex_ctrl_p0.reg_write && ex_hit) ||
                      (vld_p1 && mem_reg_write_p1 && mem_hit));
  assign flush     = vld_p0 && ex_ctrl_p0.branch && bus.ex_zero_i;

  assign insert_bubble = load_use || raw_stall || flush;
  assign bus.stall_o   = (load_use || raw_stall) && !flush;
  assign bus.flush_o   = flush;

  assign mem_fwd_src = ENABLE_FWD && vld_p1 && mem_reg_write_p1 && (mem_rd_p1 != '0);
  assign wb_fwd_src  = ENABLE_FWD && vld_p2 && wb_reg_write_p2 && (wb_rd_p2 != '0);
  assign bus.fwd_a_o = fwd_select(ex_rs1_p0, mem_fwd_src, mem_rd_p1, wb_fwd_src, wb_rd_p2);
  assign bus.fwd_b_o = fwd_select(ex_rs2_p0, mem_fwd_src, mem_rd_p1, wb_fwd_src, wb_rd_p2);

  // ID/EX stage boundary
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_ctrl_p0 <= CTRL_BUBBLE;
      vld_p0     <= 1'b0;
      ex_rs1_p0  <= '0;
      ex_rs2_p0  <= '0;
      ex_rd_p0   <= '0;
    end else if (insert_bubble || !bus.id_valid_i) begin
      ex_ctrl_p0 <= CTRL_BUBBLE;
      vld_p0     <= 1'b0;
      ex_rs1_p0  <= '0;
      ex_rs2_p0  <= '0;
      ex_rd_p0   <= '0;
    end else begin
      ex_ctrl_p0 <= id_ctrl;
      vld_p0     <= 1'b1;
      ex_rs1_p0  <= bus.id_rs1_i;
      ex_rs2_p0  <= bus.id_rs2_i;
      ex_rd_p0   <= bus.id_rd_i;
    end
  end

  // EX/MEM stage boundary
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p1           <= 1'b0;
      mem_reg_write_p1 <= 1'b0;
      mem_to_reg_p1    <= 1'b0;
      mem_read_p1      <= 1'b0;
      mem_write_p1     <= 1'b0;
      mem_rd_p1        <= '0;
    end else begin
      vld_p1           <= vld_p0;
      mem_reg_write_p1 <= ex_ctrl_p0.reg_write;
      mem_to_reg_p1    <= ex_ctrl_p0.mem_to_reg;
      mem_read_p1      <= ex_ctrl_p0.mem_read;
      mem_write_p1     <= ex_ctrl_p0.mem_write;
      mem_rd_p1        <= ex_rd_p0;
    end
  end

  // MEM/WB stage boundary
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p2           <= 1'b0;
      wb_reg_write_p2  <= 1'b0;
      wb_mem_to_reg_p2 <= 1'b0;
      wb_rd_p2         <= '0;
    end else begin
      vld_p2           <= vld_p1;
      wb_reg_write_p2  <= mem_reg_write_p1;
      wb_mem_to_reg_p2 <= mem_to_reg_p1;
      wb_rd_p2         <= mem_rd_p1;
    end
  end

  assign bus.ex_alu_op_o     = ex_ctrl_p0.alu_op;
  assign bus.ex_alu_src_o    = ex_ctrl_p0.alu_src;
  assign bus.ex_branch_o     = ex_ctrl_p0.branch;
  assign bus.ex_illegal_o    = ex_ctrl_p0.illegal;
  assign bus.mem_read_o      = mem_read_p1;
  assign bus.mem_write_o     = mem_write_p1;
  assign bus.wb_reg_write_o  = wb_reg_write_p2;
  assign bus.wb_mem_to_reg_o = wb_mem_to_reg_p2;
  assign bus.wb_rd_o         = wb_rd_p2;

endmodule

// File: doc/pipeline_control_unit.md
# pipeline_control_unit

- Parametrised, pipelined successor to the single-cycle opcode decoder.
- Decodes the RV32I opcode of the instruction in ID.
- Carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers.
- Generates load-use stall, branch flush and EX-stage operand-forwarding selects.
- Sits between the IF/ID register and the datapath of the 5-stage CPU and owns every control pipeline register.

## Interface
Parameters:
- REG_AW, 5: register-address width.
- ENABLE_FWD, 1: 1 = forward from MEM/WB stages and stall only on load-use; 0 = no forwarding, stall on every RAW hazard.

Ports:
- clk_i  in  1  clock; all registers update on its rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- id_valid_i  in  1  IF/ID holds a real instruction; 0 treated as bubble.
- id_op_i  in  7  opcode field of the ID instruction.
- id_rs1_i, id_rs2_i, id_rd_i  in  REG_AW  register fields of the ID instruction.
- ex_zero_i  in  1  ALU zero flag of the EX instruction.
- stall_o  out  1  hold PC and IF/ID this cycle.
- flush_o  out  1  branch taken; top level clears IF/ID.
- ex_alu_op_o  out  2  ALUOp in EX.
- ex_alu_src_o  out  1  ALUSrc in EX.
- ex_branch_o  out  1  Branch in EX.
- ex_illegal_o  out  1  EX instruction had an undefined opcode.
- fwd_a_o, fwd_b_o  out  2  EX operand source select: 00 regfile, 10 EX/MEM result, 01 MEM/WB result.
- mem_read_o, mem_write_o  out  1  MEM-stage memory controls.
- wb_reg_write_o, wb_mem_to_reg_o  out  1  WB-stage controls.
- wb_rd_o  out  REG_AW  WB destination register.

## Operation

Decode (combinational, ID):
- 0110011 R: RegWrite=1, ALUOp=10, uses rs1 and rs2.
- 0010011 I-ALU: RegWrite=1, ALUSrc=1, ALUOp=00, uses rs1.
- 0000011 load: RegWrite=1, MemtoReg=1, MemRead=1, ALUSrc=1, ALUOp=00, uses rs1.
- 0100011 store: MemWrite=1, ALUSrc=1, ALUOp=01, uses rs1 and rs2.
- 1100011 branch: Branch=1, ALUOp=11, uses rs1 and rs2.
- Any other opcode: all-zero bundle with illegal=1.
- id_valid_i=0: all-zero bundle with illegal=0.

Pipeline:
- ID/EX holds the bundle plus rs1, rs2, rd.
- EX/MEM and MEM/WB hold the remaining fields plus rd.
- A register whose rd = 0 never counts as a hazard source or forwarding source.

Load-use stall (either mode):
- Condition: EX MemRead=1, ex_rd≠0, and ex_rd equals an ID source register that the ID instruction actually uses.

ENABLE_FWD=0 adds a stall when:
- an ID source in use matches the rd of an EX or MEM instruction with RegWrite=1 and rd≠0.
- The register file writes through in WB, so the WB stage is never checked.

Flush:
- flush_o = ex_branch & ex_zero_i.

Stall and flush effects:
- On stall, ID/EX loads a bubble; EX/MEM and MEM/WB advance normally.
- On flush, ID/EX loads a bubble and stall_o is forced to 0. Flush has priority over stall.

Forwarding (ENABLE_FWD=1; tied to 00 otherwise):
- fwd_a = 10 if mem RegWrite, mem_rd≠0 and mem_rd = ex_rs1.
- Otherwise fwd_a = 01 if the same conditions hold for the WB stage.
- Otherwise fwd_a = 00.
- fwd_b uses the same rule against ex_rs2.

## Timing
- Decode is combinational. The bundle for the ID instruction appears on ex_* one edge later, mem_* two edges later, wb_* three edges later.
- stall_o, flush_o and fwd_*_o are combinational from current pipeline register contents and ID inputs in the same cycle.
- Reset: every pipeline register clears to the bubble immediately and asynchronously, including mid-instruction. All outputs are 0 while rst_i is high, including stall_o, flush_o, fwd_* = 00 and wb_rd_o = 0.
- First rising edge after rst_i falls loads ID normally.
- Stall lasts exactly 1 cycle for load-use. With ENABLE_FWD=0, a RAW on the immediately preceding instruction stalls 2 cycles and on the instruction two ahead stalls 1 cycle.
- Branch penalty: 2 instructions (IF/ID and ID) squashed.

## Structure
- Package ctrl_pkg holds:
  - opcode constants;
  - ALUOp encodings R=10, I=00, S=01, SB=11;
  - forwarding-select encodings;
  - the control-bundle struct.
- Sub-module control_decoder: purely combinational, id_op_i and id_valid_i to bundle, illegal flag and uses_rs1/uses_rs2.
- Hazard and forwarding logic and the three stage registers live in the top module.

## Test plan
- Reset mid-stream: assert rst_i while a load is in MEM. All outputs are 0 immediately, without waiting for a clock edge. After release, an R op reaches wb_reg_write_o=1 on the third edge.
- Load-use: `lw x5,0(x1)` then `add x6,x5,x2`.
  - stall_o=1 for exactly one cycle, and the EX bubble has all controls 0.
  - When the add is in EX, fwd_a_o=01.
- Forwarding: `add x3,x1,x2` then `sub x4,x3,x3`. fwd_a_o=fwd_b_o=10 with stall_o=0. With ENABLE_FWD=0, the same pair gives stall_o=1 for 2 cycles and fwd=00.
- x0 filter: `addi x0,x0,1` then `add x7,x0,x0` gives fwd=00 and no stall.
- Branch: beq in EX with ex_zero_i=1 gives flush_o=1 and next-cycle ex_* all 0. With a load-use pending in ID in the same cycle, stall_o=0.
- Illegal: opcode 1111111 gives ex_illegal_o=1 one edge later with all other controls 0. id_valid_i=0 gives ex_illegal_o=0.
